// File: rtl/icache_linefill_buf.sv
// Line-fill buffer: gathers returned read beats for one MSHR miss into a full line,
// writes it to the data RAM, returns it upstream, then pulses done to the owning entry.
// Optional ICACHE_LINEFILL_BYPASS_EN merges the write and response phases into one state.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_COLLECT    | accepting beats into the buffer (rxdat_rdy=1)
// S_WRITE      | line offered to the data RAM (serialized build)
// S_RESP       | line offered upstream (serialized build)
// S_WRITE_RESP | line offered to data RAM and upstream together (bypass build)
// S_DONE       | one-cycle done pulse to the owning MSHR entry
module icache_linefill_buf #(
    parameter int MSHR_ENTRY_NUM = 8,
    parameter int BEAT_NUM       = 4,
    parameter int BEAT_WIDTH     = 128,
    parameter int TXNID_WIDTH    = 8,
    parameter int INDEX_WIDTH    = 7,
    parameter int WAY_NUM        = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      rxdat_vld,
    output logic                                      rxdat_rdy,
    input  logic [TXNID_WIDTH-1:0]                    rxdat_txnid,
    input  logic [BEAT_WIDTH-1:0]                     rxdat_data,
    input  logic                                      rxdat_last,
    input  logic [MSHR_ENTRY_NUM*INDEX_WIDTH-1:0]     v_entry_index,
    input  logic [MSHR_ENTRY_NUM*$clog2(WAY_NUM)-1:0] v_entry_way,
    output logic                                      dataram_wr_vld,
    input  logic                                      dataram_wr_rdy,
    output logic [INDEX_WIDTH-1:0]                    dataram_wr_index,
    output logic [$clog2(WAY_NUM)-1:0]                dataram_wr_way,
    output logic [BEAT_NUM*BEAT_WIDTH-1:0]            dataram_wr_data,
    output logic                                      resp_vld,
    input  logic                                      resp_rdy,
    output logic [TXNID_WIDTH-1:0]                    resp_txnid,
    output logic [BEAT_NUM*BEAT_WIDTH-1:0]            resp_data,
    output logic [MSHR_ENTRY_NUM-1:0]                 v_linefill_done,
    output logic                                      err_proto
);

    localparam int ENTRY_W = $clog2(MSHR_ENTRY_NUM);
    localparam int WAY_W   = $clog2(WAY_NUM);
    localparam int CNT_W   = $clog2(BEAT_NUM);

`ifdef ICACHE_LINEFILL_BYPASS_EN
    typedef enum logic [1:0] {
        S_COLLECT    = 2'd0,
        S_WRITE_RESP = 2'd1,
        S_DONE       = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WRITE   = 2'd1,
        S_RESP    = 2'd2,
        S_DONE    = 2'd3
    } state_t;
`endif

    state_t                                 state;
    state_t                                 state_nxt;
    logic   [CNT_W-1:0]                     beat_cnt;
    logic   [BEAT_NUM-1:0][BEAT_WIDTH-1:0]  line_buf;
    logic   [TXNID_WIDTH-1:0]               txnid_q;
    logic   [ENTRY_W-1:0]                   entry_q;
    logic   [INDEX_WIDTH-1:0]               index_q;
    logic   [WAY_W-1:0]                     way_q;
    logic                                   err_q;

    logic                                   rx_hs;
    logic                                   beat_is_end;
    logic                                   line_end;
    logic   [ENTRY_W-1:0]                   entry_in;

    assign rx_hs       = rxdat_vld & rxdat_rdy;
    assign beat_is_end = (beat_cnt == CNT_W'(BEAT_NUM - 1));
    // A line closes on last or on the final slot, whichever comes first.
    assign line_end    = rx_hs & (rxdat_last | beat_is_end);
    assign entry_in    = rxdat_txnid[ENTRY_W-1:0];

`ifdef ICACHE_LINEFILL_BYPASS_EN
    logic wr_sent_q;
    logic resp_sent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sent_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else if (state == S_WRITE_RESP) begin
            if (dataram_wr_vld && dataram_wr_rdy) wr_sent_q   <= 1'b1;
            if (resp_vld && resp_rdy)             resp_sent_q <= 1'b1;
        end else begin
            wr_sent_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: begin
`ifdef ICACHE_LINEFILL_BYPASS_EN
                if (line_end) state_nxt = S_WRITE_RESP;
`else
                if (line_end) state_nxt = S_WRITE;
`endif
            end
`ifdef ICACHE_LINEFILL_BYPASS_EN
            S_WRITE_RESP: begin
                if ((wr_sent_q | dataram_wr_rdy) && (resp_sent_q | resp_rdy)) state_nxt = S_DONE;
            end
`else
            S_WRITE: begin
                if (dataram_wr_rdy) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (resp_rdy) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                state_nxt = S_COLLECT;
            end
            default: begin
                state_nxt = S_COLLECT;
            end
        endcase
    end

    always_comb begin
        rxdat_rdy       = (state == S_COLLECT);
`ifdef ICACHE_LINEFILL_BYPASS_EN
        dataram_wr_vld  = (state == S_WRITE_RESP) && !wr_sent_q;
        resp_vld        = (state == S_WRITE_RESP) && !resp_sent_q;
`else
        dataram_wr_vld  = (state == S_WRITE);
        resp_vld        = (state == S_RESP);
`endif
        v_linefill_done = '0;
        if (state == S_DONE) v_linefill_done[entry_q] = 1'b1;
    end

    // Buffer and tags only move in COLLECT, so the payload is frozen while any vld is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            line_buf <= '0;
            txnid_q  <= '0;
            entry_q  <= '0;
            index_q  <= '0;
            way_q    <= '0;
            err_q    <= 1'b0;
        end else if (rx_hs) begin
            line_buf[beat_cnt] <= rxdat_data;
            if (beat_cnt == '0) begin
                txnid_q <= rxdat_txnid;
                entry_q <= entry_in;
                index_q <= v_entry_index[entry_in*INDEX_WIDTH +: INDEX_WIDTH];
                way_q   <= v_entry_way[entry_in*WAY_W +: WAY_W];
            end else if (rxdat_txnid != txnid_q) begin
                err_q <= 1'b1;
            end
            if (rxdat_last != beat_is_end) err_q <= 1'b1;
            beat_cnt <= line_end ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign dataram_wr_index = index_q;
    assign dataram_wr_way   = way_q;
    assign dataram_wr_data  = line_buf;
    assign resp_txnid       = txnid_q;
    assign resp_data        = line_buf;
    assign err_proto        = err_q;

    a_wr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        dataram_wr_vld && !dataram_wr_rdy |=> dataram_wr_vld && $stable(dataram_wr_data));
    a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        resp_vld && !resp_rdy |=> resp_vld && $stable(resp_data));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(v_linefill_done));

endmodule
